bsg_manycore_ruche_x_link_relay: RTL and testbench
==================================================

# bsg_manycore_ruche_x_link_relay

Pipelined relay inserted on the horizontal ruche X links between two adjacent compute tiles. It sits between one tile's east ruche output and the next tile's west ruche input, and on the opposite path. It breaks long ruche wires with one register stage per channel and preserves full throughput with a 2-entry elastic buffer. It handles all ruche lanes, both travel directions, and both the fwd and rev networks. Packets are carried unmodified in the ruche (src_y / dest_y filtered) format.

## Interface
- addr_width_p, "inv", manycore packet address width
- data_width_p, "inv", manycore packet data width
- x_cord_width_p, "inv", global x coordinate width
- y_cord_width_p, "inv", global y coordinate width
- ruche_factor_X_p, 3, number of ruche lanes relayed
- lane_buffer_p, {ruche_factor_X_p{1'b1}}, per-lane enable: 1 = buffered, 0 = combinational wire-through
- ruche_x_link_sif_width_lp, derived, `bsg_manycore_ruche_x_link_sif_width(addr,data,x,y)`
- clk_i  input  1  single clock
- reset_i  input  1  reset, asynchronous, active-high
- w_link_i  input  [ruche_factor_X_p-1:0][ruche_x_link_sif_width_lp]  link from west tile (its east ruche output)
- w_link_o  output  same  link to west tile (its east ruche input)
- e_link_i  input  same  link from east tile (its west ruche output)
- e_link_o  output  same  link to east tile (its west ruche input)

Each link sif carries fwd and rev channels. Each channel has fields {v, data, ready_and_rev}. A link_o's ready_and_rev acknowledges the same channel arriving on the same side's link_i.

## Operation
- Per lane i, four independent channel buffers:
  - EF: w_link_i[i].fwd → e_link_o[i].fwd
  - ER: w_link_i[i].rev → e_link_o[i].rev
  - WF: e_link_i[i].fwd → w_link_o[i].fwd
  - WR: e_link_i[i].rev → w_link_o[i].rev
- Ready routing: the EF buffer's ready drives w_link_o[i].fwd.ready_and_rev. Its dequeue occurs when e_link_o[i].fwd.v & e_link_i[i].fwd.ready_and_rev. The other three buffers are symmetric.
- Buffer: 2-entry FIFO with head/tail registers and a 2-bit count (0..2).
  - enq = in.v & ready_out
  - deq = out.v & ready_in
- ready_out = (count != 2). It is derived only from registered state, with no combinational path from ready_in.
- out.v = (count != 0); out.data = head entry.
- Count update: enq & ~deq → +1; deq & ~enq → −1; both → unchanged.
  - Simultaneous enq/deq at count 1: the new packet becomes head.
  - Simultaneous enq/deq at count 2: the tail shifts to head and the new packet becomes tail.
- Enq at count 2 cannot occur because ready_out is 0. A sender presenting v while ready is 0 is held; no data is dropped or overwritten.
- Packets leave in arrival order per buffer. No reordering across buffers is defined.
- lane_buffer_p[i] = 0: all four channels of lane i are assigned straight through, ready included. There is no state and zero latency.
- No packet field is inspected or altered.

## Timing
- Reset (async assert, synchronous release on clk_i):
  - count = 0; head/tail = 0
  - All out.v = 0 and out.data = 0
  - All ready_and_rev outputs = 1 (empty)
- Latency: a packet enqueued at edge N is visible on the output (v=1) after edge N, i.e. it can be accepted downstream at edge N+1. One-cycle latency when the buffer is empty.
- Throughput: one packet per cycle per buffer sustained, provided ready_in stays high.
- Backpressure: when ready_in drops, the buffer absorbs at most 2 packets. ready_out falls the cycle after count reaches 2 and rises the cycle after the first dequeue from full.
- Reset asserted mid-traffic: all buffered packets are discarded immediately, asynchronously. Outputs take reset values within the same cycle.

## Test plan
- Single packet: EF lane 0, data 0xA5 injected with v for 1 cycle, e_link_i ready=1 → e_link_o[0].fwd.v=1 with data 0xA5 for exactly one cycle, one cycle later.
- Streaming: 16 back-to-back WR packets 0..15 on lane 2 with ready held 1 → 16 consecutive output cycles, values in order 0..15, ready_and_rev never 0.
- Backpressure: ready_in=0 while sending 0x1,0x2,0x3 on EF → ready_out=0 after 2 accepted, 0x3 held at source. After ready_in=1 → outputs 0x1,0x2,0x3 in order, no loss.
- Full simultaneous: count=2 holding {0x1,0x2}, deq and new 0x3 presented the cycle ready re-rises → final output order 0x1,0x2,0x3, count never exceeds 2.
- Reset mid-operation: assert reset_i asynchronously (between edges) with count=2 on all four buffers → all v=0, data=0, ready=1 before the next edge. Post-release, the first new packet emerges with 1-cycle latency.
- Bypass: lane_buffer_p=3'b101, packet on lane 1 → appears on the output the same cycle and ready passes through combinationally. Lanes 0/2 keep 1-cycle latency.

Source files
------------

// File: rtl/bsg_manycore_ruche_x_link_relay.sv
// Ruche X link relay: one elastic 2-entry buffer per channel (fwd/rev, both
// directions) on every ruche lane, or a plain wire-through for unbuffered lanes.

module bsg_manycore_ruche_x_link_relay_buf #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_and_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_and_i
);
   logic [width_p-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]         count_q, count_d;
   logic               enq, deq;

   // ready depends on registered count only, so no ready path crosses the relay
   assign ready_and_o = (count_q != 2'd2);
   assign v_o         = (count_q != 2'd0);
   assign data_o      = head_q;
   assign enq         = v_i & ready_and_o;
   assign deq         = v_o & ready_and_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({enq, deq})
         2'b10: begin
            count_d = count_q + 2'd1;
            if (count_q == 2'd0) head_d = data_i;
            else                 tail_d = data_i;
         end
         2'b01: begin
            count_d = count_q - 2'd1;
            if (count_q == 2'd2) head_d = tail_q;
         end
         2'b11: begin
            if (count_q == 2'd1) head_d = data_i;
            else begin
               head_d = tail_q;
               tail_d = data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

module bsg_manycore_ruche_x_link_relay #(
   parameter int addr_width_p     = 8,
   parameter int data_width_p     = 8,
   parameter int x_cord_width_p   = 4,
   parameter int y_cord_width_p   = 4,
   parameter int ruche_factor_X_p = 3,
   parameter logic [ruche_factor_X_p-1:0] lane_buffer_p = {ruche_factor_X_p{1'b1}},
   // ruche packets: payload + src/dest x + the single y field left after filtering
   localparam int fwd_width_lp = addr_width_p + data_width_p + 2*x_cord_width_p + y_cord_width_p,
   localparam int rev_width_lp = data_width_p + x_cord_width_p,
   localparam int ruche_x_link_sif_width_lp = fwd_width_lp + rev_width_lp + 4
) (
   input  logic                                                clk_i,
   input  logic                                                reset_i,
   input  logic [ruche_factor_X_p-1:0][ruche_x_link_sif_width_lp-1:0] w_link_i,
   output logic [ruche_factor_X_p-1:0][ruche_x_link_sif_width_lp-1:0] w_link_o,
   input  logic [ruche_factor_X_p-1:0][ruche_x_link_sif_width_lp-1:0] e_link_i,
   output logic [ruche_factor_X_p-1:0][ruche_x_link_sif_width_lp-1:0] e_link_o
);
   // sif layout, MSB first: fwd {v, data, ready_and_rev}, rev {v, data, ready_and_rev}
   for (genvar i = 0; i < ruche_factor_X_p; i++) begin : lane
      for (genvar n = 0; n < 2; n++) begin : net
         localparam int w_lp = (n == 0) ? fwd_width_lp : rev_width_lp;
         localparam int b_lp = (n == 0) ? rev_width_lp + 2 : 0;

         if (lane_buffer_p[i]) begin : buffered
            bsg_manycore_ruche_x_link_relay_buf #(.width_p(w_lp)) east (
               .clk_i       (clk_i),
               .reset_i     (reset_i),
               .v_i         (w_link_i[i][b_lp+w_lp+1]),
               .data_i      (w_link_i[i][b_lp+w_lp:b_lp+1]),
               .ready_and_o (w_link_o[i][b_lp]),
               .v_o         (e_link_o[i][b_lp+w_lp+1]),
               .data_o      (e_link_o[i][b_lp+w_lp:b_lp+1]),
               .ready_and_i (e_link_i[i][b_lp])
            );
            bsg_manycore_ruche_x_link_relay_buf #(.width_p(w_lp)) west (
               .clk_i       (clk_i),
               .reset_i     (reset_i),
               .v_i         (e_link_i[i][b_lp+w_lp+1]),
               .data_i      (e_link_i[i][b_lp+w_lp:b_lp+1]),
               .ready_and_o (e_link_o[i][b_lp]),
               .v_o         (w_link_o[i][b_lp+w_lp+1]),
               .data_o      (w_link_o[i][b_lp+w_lp:b_lp+1]),
               .ready_and_i (w_link_i[i][b_lp])
            );
         end else begin : thru
            assign e_link_o[i][b_lp+w_lp+1:b_lp+1] = w_link_i[i][b_lp+w_lp+1:b_lp+1];
            assign w_link_o[i][b_lp]               = e_link_i[i][b_lp];
            assign w_link_o[i][b_lp+w_lp+1:b_lp+1] = e_link_i[i][b_lp+w_lp+1:b_lp+1];
            assign e_link_o[i][b_lp]               = w_link_i[i][b_lp];
         end
      end
   end
endmodule

// File: tb/tb_bsg_manycore_ruche_x_link_relay.sv
// Bench for the ruche X link relay: latency, streaming, backpressure, async reset, bypass lane.

module tb_bsg_manycore_ruche_x_link_relay;
   localparam int AW = 8, DW = 8, XW = 4, YW = 4, NL = 3;
   localparam int FW = AW + DW + 2*XW + YW;
   localparam int RW = DW + XW;
   localparam int SW = FW + RW + 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NL-1:0][SW-1:0] w_link_i, w_link_o, e_link_i, e_link_o;

   // [side][lane][net]: side 0 = west ports, 1 = east ports; net 0 = fwd, 1 = rev
   logic          in_v  [2][NL][2];
   logic [FW-1:0] in_d  [2][NL][2];
   logic          in_r  [2][NL][2];
   logic          out_v [2][NL][2];
   logic [FW-1:0] out_d [2][NL][2];
   logic          out_r [2][NL][2];

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   bsg_manycore_ruche_x_link_relay #(
      .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
      .ruche_factor_X_p(NL), .lane_buffer_p(3'b101)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .w_link_i(w_link_i), .w_link_o(w_link_o),
      .e_link_i(e_link_i), .e_link_o(e_link_o)
   );

   always_comb begin
      for (int l = 0; l < NL; l++) begin
         w_link_i[l] = {in_v[0][l][0], in_d[0][l][0], in_r[0][l][0],
                        in_v[0][l][1], in_d[0][l][1][RW-1:0], in_r[0][l][1]};
         e_link_i[l] = {in_v[1][l][0], in_d[1][l][0], in_r[1][l][0],
                        in_v[1][l][1], in_d[1][l][1][RW-1:0], in_r[1][l][1]};
      end
   end

   always_comb begin
      for (int l = 0; l < NL; l++) begin
         out_v[0][l][0] = w_link_o[l][SW-1];
         out_d[0][l][0] = w_link_o[l][SW-2 -: FW];
         out_r[0][l][0] = w_link_o[l][RW+2];
         out_v[0][l][1] = w_link_o[l][RW+1];
         out_d[0][l][1] = {{(FW-RW){1'b0}}, w_link_o[l][RW:1]};
         out_r[0][l][1] = w_link_o[l][0];
         out_v[1][l][0] = e_link_o[l][SW-1];
         out_d[1][l][0] = e_link_o[l][SW-2 -: FW];
         out_r[1][l][0] = e_link_o[l][RW+2];
         out_v[1][l][1] = e_link_o[l][RW+1];
         out_d[1][l][1] = {{(FW-RW){1'b0}}, e_link_o[l][RW:1]};
         out_r[1][l][1] = e_link_o[l][0];
      end
   end

   task automatic idle();
      for (int s = 0; s < 2; s++)
         for (int l = 0; l < NL; l++)
            for (int n = 0; n < 2; n++) begin
               in_v[s][l][n] = 1'b0;
               in_d[s][l][n] = '0;
               in_r[s][l][n] = 1'b1;
            end
   endtask

   task automatic test_reset();
      idle();
      #2;
      for (int s = 0; s < 2; s++)
         for (int l = 0; l < NL; l++)
            for (int n = 0; n < 2; n++) begin
               checks++;
               if (out_v[s][l][n] !== 1'b0 || out_d[s][l][n] !== '0 || out_r[s][l][n] !== 1'b1) begin
                  fails++;
                  $display("FAIL reset_state s%0d l%0d n%0d: got v=%b d=%h r=%b expected v=0 d=0 r=1",
                           s, l, n, out_v[s][l][n], out_d[s][l][n], out_r[s][l][n]);
               end
            end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // EF lane 0: one packet, one-cycle latency, one-cycle visibility
   task automatic test_single();
      in_v[0][0][0] = 1'b1; in_d[0][0][0] = FW'('hA5);
      @(negedge clk);
      checks++;
      if (out_v[1][0][0] !== 1'b0 || out_r[0][0][0] !== 1'b1) begin
         fails++;
         $display("FAIL single_pre: got v=%b r=%b expected v=0 r=1", out_v[1][0][0], out_r[0][0][0]);
      end
      @(posedge clk); #1; in_v[0][0][0] = 1'b0;
      @(negedge clk);
      checks++;
      if (out_v[1][0][0] !== 1'b1 || out_d[1][0][0] !== FW'('hA5)) begin
         fails++;
         $display("FAIL single_out: got v=%b d=%h expected v=1 d=a5", out_v[1][0][0], out_d[1][0][0]);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_v[1][0][0] !== 1'b0) begin
         fails++;
         $display("FAIL single_once: got v=%b expected 0", out_v[1][0][0]);
      end
      @(posedge clk); #1;
   endtask

   // WR lane 2: 16 back-to-back packets
   task automatic test_stream();
      logic [FW-1:0] exp_q[$];
      logic [FW-1:0] e;
      int sent = 0, got = 0, first = -1, last = -1, rdy_lo = 0;
      for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
         in_v[1][2][1] = (sent < 16);
         in_d[1][2][1] = FW'(sent);
         @(negedge clk);
         if (out_r[1][2][1] !== 1'b1) rdy_lo++;
         if (in_v[1][2][1] && out_r[1][2][1]) begin exp_q.push_back(FW'(sent)); sent++; end
         if (out_v[0][2][1] === 1'b1 && in_r[0][2][1]) begin
            if (first < 0) first = cyc;
            last = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL stream_extra: got %h expected nothing", out_d[0][2][1]);
            end else begin
               e = exp_q.pop_front();
               if (out_d[0][2][1] !== e) begin
                  fails++;
                  $display("FAIL stream_data: got %h expected %h", out_d[0][2][1], e);
               end
            end
            got++;
         end
         @(posedge clk); #1;
      end
      in_v[1][2][1] = 1'b0;
      checks++;
      if (got != 16) begin fails++; $display("FAIL stream_count: got %0d expected 16", got); end
      checks++;
      if (last - first != 15) begin
         fails++; $display("FAIL stream_contig: got span %0d expected 15", last - first);
      end
      checks++;
      if (rdy_lo != 0) begin fails++; $display("FAIL stream_ready: got %0d low cycles expected 0", rdy_lo); end
   endtask

   // EF lane 0: sink stalls while 1,2,3 are offered, then drains
   task automatic test_backpressure();
      logic [FW-1:0] vals[3];
      logic [FW-1:0] exp_q[$];
      logic [FW-1:0] e;
      int sent = 0, got = 0;
      vals[0] = FW'(1); vals[1] = FW'(2); vals[2] = FW'(3);
      in_r[1][0][0] = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         in_v[0][0][0] = (sent < 3);
         in_d[0][0][0] = (sent < 3) ? vals[sent] : '0;
         @(negedge clk);
         if (in_v[0][0][0] && out_r[0][0][0]) begin exp_q.push_back(vals[sent]); sent++; end
         @(posedge clk); #1;
      end
      checks++;
      if (sent != 2) begin fails++; $display("FAIL bp_accepted: got %0d expected 2", sent); end
      checks++;
      if (out_r[0][0][0] !== 1'b0) begin fails++; $display("FAIL bp_ready_low: got %b expected 0", out_r[0][0][0]); end
      in_r[1][0][0] = 1'b1;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
         in_v[0][0][0] = (sent < 3);
         in_d[0][0][0] = (sent < 3) ? vals[sent] : '0;
         @(negedge clk);
         if (in_v[0][0][0] && out_r[0][0][0]) begin exp_q.push_back(vals[sent]); sent++; end
         if (out_v[1][0][0] === 1'b1) begin
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            if (out_d[1][0][0] !== e) begin
               fails++; $display("FAIL bp_data: got %h expected %h", out_d[1][0][0], e);
            end
            got++;
         end
         @(posedge clk); #1;
      end
      in_v[0][0][0] = 1'b0;
      checks++;
      if (got != 3) begin fails++; $display("FAIL bp_drain: got %0d expected 3", got); end
   endtask

   // WF lane 2: full buffer drains while the held packet enters alongside a dequeue
   task automatic test_full_simul();
      logic [FW-1:0] vals[3];
      logic [FW-1:0] exp_q[$];
      logic [FW-1:0] e;
      int sent = 0, got = 0, rise = -1, over = 0;
      int ocyc[3];
      vals[0] = FW'('h11); vals[1] = FW'('h22); vals[2] = FW'('h33);
      in_r[0][2][0] = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         in_v[1][2][0] = (sent < 3);
         in_d[1][2][0] = (sent < 3) ? vals[sent] : '0;
         @(negedge clk);
         if (in_v[1][2][0] && out_r[1][2][0]) begin exp_q.push_back(vals[sent]); sent++; end
         @(posedge clk); #1;
      end
      in_r[0][2][0] = 1'b1;
      for (int k = 0; k < 10 && got < 3; k++) begin
         in_v[1][2][0] = (sent < 3);
         in_d[1][2][0] = (sent < 3) ? vals[sent] : '0;
         @(negedge clk);
         if (rise < 0 && out_r[1][2][0] === 1'b1) rise = k;
         if (in_v[1][2][0] && out_r[1][2][0]) begin exp_q.push_back(vals[sent]); sent++; end
         if (out_v[0][2][0] === 1'b1) begin
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            if (out_d[0][2][0] !== e) begin
               fails++; $display("FAIL full_data: got %h expected %h", out_d[0][2][0], e);
            end
            ocyc[got] = k;
            got++;
         end
         if (sent - got > 2) over++;
         @(posedge clk); #1;
      end
      in_v[1][2][0] = 1'b0;
      checks++;
      if (got != 3 || ocyc[0] != 0 || ocyc[1] != 1 || ocyc[2] != 2) begin
         fails++; $display("FAIL full_timing: got %0d outputs expected 3 on cycles 0,1,2", got);
      end
      checks++;
      if (rise != 1) begin fails++; $display("FAIL full_ready_rise: got cycle %0d expected 1", rise); end
      checks++;
      if (over != 0) begin fails++; $display("FAIL full_occupancy: got %0d overflows expected 0", over); end
   endtask

   // lane 0, all four buffers full, then reset between edges
   task automatic test_reset_mid();
      for (int s = 0; s < 2; s++)
         for (int n = 0; n < 2; n++) begin
            in_r[s][0][n] = 1'b0;
            in_v[s][0][n] = 1'b1;
            in_d[s][0][n] = FW'('h40 + 4*s + n);
         end
      repeat (3) begin @(posedge clk); #1; end
      for (int s = 0; s < 2; s++)
         for (int n = 0; n < 2; n++) begin
            checks++;
            if (out_v[s][0][n] !== 1'b1 || out_r[s][0][n] !== 1'b0) begin
               fails++; $display("FAIL mid_full s%0d n%0d: got v=%b r=%b expected v=1 r=0",
                                 s, n, out_v[s][0][n], out_r[s][0][n]);
            end
         end
      #2 rst = 1'b1;
      #1;
      for (int s = 0; s < 2; s++)
         for (int n = 0; n < 2; n++) begin
            checks++;
            if (out_v[s][0][n] !== 1'b0 || out_d[s][0][n] !== '0 || out_r[s][0][n] !== 1'b1) begin
               fails++; $display("FAIL mid_reset s%0d n%0d: got v=%b d=%h r=%b expected v=0 d=0 r=1",
                                 s, n, out_v[s][0][n], out_d[s][0][n], out_r[s][0][n]);
            end
         end
      idle();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      in_v[0][0][0] = 1'b1; in_d[0][0][0] = FW'('h5A);
      @(negedge clk);
      checks++;
      if (out_v[1][0][0] !== 1'b0) begin fails++; $display("FAIL mid_post_pre: got v=%b expected 0", out_v[1][0][0]); end
      @(posedge clk); #1; in_v[0][0][0] = 1'b0;
      @(negedge clk);
      checks++;
      if (out_v[1][0][0] !== 1'b1 || out_d[1][0][0] !== FW'('h5A)) begin
         fails++; $display("FAIL mid_post: got v=%b d=%h expected v=1 d=5a", out_v[1][0][0], out_d[1][0][0]);
      end
      @(posedge clk); #1;
   endtask

   // lane 1 is wired through; lane 0 beside it must still be registered
   task automatic test_bypass();
      in_v[0][1][0] = 1'b1; in_d[0][1][0] = FW'('h3C); in_r[1][1][0] = 1'b0;
      in_v[1][1][1] = 1'b1; in_d[1][1][1] = FW'('h7E);
      in_v[0][0][0] = 1'b1; in_d[0][0][0] = FW'('h99);
      #1;
      checks++;
      if (out_v[1][1][0] !== 1'b1 || out_d[1][1][0] !== FW'('h3C)) begin
         fails++; $display("FAIL bypass_ef: got v=%b d=%h expected v=1 d=3c", out_v[1][1][0], out_d[1][1][0]);
      end
      checks++;
      if (out_r[0][1][0] !== 1'b0) begin fails++; $display("FAIL bypass_ready_lo: got %b expected 0", out_r[0][1][0]); end
      checks++;
      if (out_v[0][1][1] !== 1'b1 || out_d[0][1][1] !== FW'('h7E)) begin
         fails++; $display("FAIL bypass_wr: got v=%b d=%h expected v=1 d=7e", out_v[0][1][1], out_d[0][1][1]);
      end
      checks++;
      if (out_v[1][0][0] !== 1'b0) begin fails++; $display("FAIL bypass_lane0: got v=%b expected 0", out_v[1][0][0]); end
      in_r[1][1][0] = 1'b1;
      #1;
      checks++;
      if (out_r[0][1][0] !== 1'b1) begin fails++; $display("FAIL bypass_ready_hi: got %b expected 1", out_r[0][1][0]); end
      idle();
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_full_simul();
      test_reset_mid();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
